// File: rtl/led_flash_stretcher.sv
// Stretches one-cycle event pulses into a PWM LED flash: hold at the latched
// brightness for HOLD_TICKS ticks, then fade linearly to dark; keeps debug statistics.
module led_flash_stretcher #(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned HOLD_TICKS = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                tick,
    input  logic                event_in,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                led,
    output logic                busy,
    output logic                retrig,
    output logic [7:0]          event_count
);

    localparam int unsigned CNT_BITS = 8;
    localparam logic [CNT_BITS-1:0] HOLD_LOAD = CNT_BITS'(HOLD_TICKS);
    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_FADE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0]   duty_q, duty_d;
    logic [CNT_BITS-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_BITS-1:0]   event_count_q, event_count_d;
    logic                  retrig_q, retrig_d;
    logic                  led_q, led_d;
    logic                  busy_q, busy_d;

    // Next-state and statistics; an event always wins over a coincident tick.
    always_comb begin
        state_d       = state_q;
        pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
        duty_d        = duty_q;
        hold_cnt_d    = hold_cnt_q;
        event_count_d = event_count_q;
        retrig_d      = retrig_q;

        if (event_in) begin
            state_d    = ST_HOLD;
            duty_d     = brightness;
            hold_cnt_d = HOLD_LOAD;
            if (state_q != ST_IDLE) begin
                retrig_d = 1'b1;
            end
            if (event_count_q != CNT_MAX) begin
                event_count_d = event_count_q + CNT_BITS'(1);
            end
        end else if (tick) begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_cnt_q == CNT_BITS'(1)) begin
                        state_d = ST_FADE;
                    end else begin
                        hold_cnt_d = hold_cnt_q - CNT_BITS'(1);
                    end
                end
                ST_FADE: begin
                    if (duty_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        duty_d = duty_q - PWM_BITS'(1);
                    end
                end
                default: state_d = state_q;
            endcase
        end

        // busy mirrors the state register one-for-one, so it is registered from state_d.
        busy_d = (state_d != ST_IDLE);
        led_d  = (state_q != ST_IDLE) && (pwm_cnt_q < duty_q);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= ST_IDLE;
            pwm_cnt_q     <= '0;
            duty_q        <= '0;
            hold_cnt_q    <= '0;
            event_count_q <= '0;
            retrig_q      <= 1'b0;
            led_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pwm_cnt_q     <= pwm_cnt_d;
            duty_q        <= duty_d;
            hold_cnt_q    <= hold_cnt_d;
            event_count_q <= event_count_d;
            retrig_q      <= retrig_d;
            led_q         <= led_d;
            busy_q        <= busy_d;
        end
    end

    assign led         = led_q;
    assign busy        = busy_q;
    assign retrig      = retrig_q;
    assign event_count = event_count_q;

endmodule
